// File: rtl/db_mcu_port.sv
// db_mcu_port: debug access port sitting between the core and its memory /
// register file. In RUN the core owns the buses; once the debugger halts the
// core it can issue single memory or register accesses, read back captured
// data and pulse a core reset.
module db_mcu_port (
    input  logic        clk,
    input  logic        reset,
    input  logic        db_active,
    input  logic        db_fsm_pause,
    input  logic [31:0] db_mem_addr,
    input  logic [1:0]  db_mem_size,
    input  logic        db_mem_rd,
    input  logic        db_mem_wr,
    input  logic [4:0]  db_rf_addr,
    input  logic        db_rf_rd,
    input  logic        db_rf_wr,
    input  logic [31:0] db_d_wr,
    input  logic        db_reset,
    input  logic [31:0] core_mem_addr,
    input  logic [31:0] core_mem_wdata,
    input  logic [1:0]  core_mem_size,
    input  logic        core_mem_re,
    input  logic        core_mem_we,
    input  logic [4:0]  core_rf_addr,
    input  logic        core_rf_we,
    input  logic [31:0] core_rf_wdata,
    input  logic [31:0] mem_rdata,
    input  logic [31:0] rf_rdata,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [1:0]  mem_size,
    output logic        mem_re,
    output logic        mem_we,
    output logic [4:0]  rf_addr,
    output logic        rf_we,
    output logic [31:0] rf_wdata,
    output logic        pc_hold,
    output logic        fsm_hold,
    output logic        core_reset,
    output logic [31:0] mem_d_out,
    output logic [31:0] rf_d_out,
    output logic        db_busy,
    output logic        db_err
);

    typedef enum logic [2:0] {RUN, HALT, MEM1, MEM2, RF} state_t;

    state_t      state_q;
    logic [31:0] addr_q;
    logic [1:0]  size_q;
    logic [31:0] wdata_q;
    logic        mem_wr_q;
    logic [4:0]  rf_addr_q;
    logic        rf_wr_q;
    logic [31:0] mem_d_q;
    logic [31:0] rf_d_q;
    logic        err_q;
    logic        core_reset_q;

    logic mem_req, rf_req, any_req, misalign;

    assign mem_req  = db_mem_rd | db_mem_wr;
    assign rf_req   = db_rf_rd | db_rf_wr;
    assign any_req  = mem_req | rf_req;
    // Reserved size, or a half/word access that is not naturally aligned.
    assign misalign = (db_mem_size == 2'd3) ||
                      (db_mem_size == 2'd1 && db_mem_addr[0]) ||
                      (db_mem_size == 2'd2 && db_mem_addr[1:0] != 2'b00);

    assign pc_hold    = db_active;
    assign fsm_hold   = db_fsm_pause | (state_q != RUN);
    assign db_busy    = (state_q == MEM1) | (state_q == MEM2) | (state_q == RF);
    assign db_err     = err_q;
    assign core_reset = core_reset_q;
    assign mem_d_out  = mem_d_q;
    assign rf_d_out   = rf_d_q;

    // Control FSM: accepts debug strobes in HALT, sequences the access and
    // captures read data; db_reset aborts whatever is in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= RUN;
            addr_q       <= '0;
            size_q       <= '0;
            wdata_q      <= '0;
            mem_wr_q     <= 1'b0;
            rf_addr_q    <= '0;
            rf_wr_q      <= 1'b0;
            mem_d_q      <= '0;
            rf_d_q       <= '0;
            err_q        <= 1'b0;
            core_reset_q <= 1'b0;
        end else if (db_reset) begin
            state_q      <= db_fsm_pause ? HALT : RUN;
            core_reset_q <= 1'b1;
            err_q        <= 1'b0;
        end else begin
            core_reset_q <= 1'b0;
            case (state_q)
                RUN: begin
                    if (any_req) err_q <= 1'b1;
                    if (db_active && db_fsm_pause) state_q <= HALT;
                end
                HALT: begin
                    if (mem_req) begin
                        // Memory wins over a simultaneous rf strobe; write wins over read.
                        if (rf_req || (db_mem_rd && db_mem_wr) || misalign) err_q <= 1'b1;
                        if (!misalign) begin
                            addr_q   <= db_mem_addr;
                            size_q   <= db_mem_size;
                            wdata_q  <= db_d_wr;
                            mem_wr_q <= db_mem_wr;
                            state_q  <= MEM1;
                        end
                    end else if (rf_req) begin
                        // rf read and write together: write wins, flagged.
                        if (db_rf_rd && db_rf_wr) err_q <= 1'b1;
                        rf_addr_q <= db_rf_addr;
                        rf_wr_q   <= db_rf_wr;
                        wdata_q   <= db_d_wr;
                        state_q   <= RF;
                    end else if (!db_fsm_pause) begin
                        state_q <= RUN;
                    end
                end
                MEM1: begin
                    if (any_req) err_q <= 1'b1;
                    state_q <= MEM2;
                end
                MEM2: begin
                    if (any_req) err_q <= 1'b1;
                    if (!mem_wr_q) mem_d_q <= mem_rdata;
                    state_q <= HALT;
                end
                RF: begin
                    if (any_req) err_q <= 1'b1;
                    if (!rf_wr_q) rf_d_q <= (rf_addr_q == 5'd0) ? 32'd0 : rf_rdata;
                    state_q <= HALT;
                end
                default: state_q <= RUN;
            endcase
        end
    end

    // Bus mux: core passes through in RUN, is masked while halted, and the
    // latched debug request drives the buses during its access states.
    always_comb begin
        mem_addr  = core_mem_addr;
        mem_wdata = core_mem_wdata;
        mem_size  = core_mem_size;
        mem_re    = 1'b0;
        mem_we    = 1'b0;
        rf_addr   = core_rf_addr;
        rf_we     = 1'b0;
        rf_wdata  = core_rf_wdata;
        case (state_q)
            RUN: begin
                mem_re = core_mem_re;
                mem_we = core_mem_we;
                rf_we  = core_rf_we;
            end
            MEM1: begin
                mem_addr  = addr_q;
                mem_wdata = wdata_q;
                mem_size  = size_q;
                mem_re    = ~mem_wr_q;
                mem_we    = mem_wr_q;
            end
            MEM2: begin
                mem_addr  = addr_q;
                mem_wdata = wdata_q;
                mem_size  = size_q;
            end
            RF: begin
                rf_addr  = rf_addr_q;
                rf_wdata = wdata_q;
                rf_we    = rf_wr_q && (rf_addr_q != 5'd0);
            end
            default: ;
        endcase
    end

endmodule
